mean_tree_pipe: RTL and testbench
=================================

MEAN_TREE_PIPE -- requirements
Module: mean_tree_pipe

Interface
REQ-001 Parameter WID, default 16, SHALL set the bit width of each input sample and of o_mean (legal range 2..32).
REQ-002 Parameter LOG2N, default 3, SHALL set the input count N = 2**LOG2N (legal range 1..6).
REQ-003 Parameter SIGNED, default 0, SHALL select sample format: 0 = unsigned, 1 = two's complement.
REQ-004 Parameter ROUND, default 0, SHALL select division mode: 0 = truncate toward minus infinity, 1 = round half up.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-007 Port in_valid, input, 1 bit, SHALL qualify in_data for the current cycle.
REQ-008 Port in_data, input, N*WID bits, SHALL carry the N samples; sample k occupies bits [k*WID+WID-1 : k*WID].
REQ-009 Port out_valid, output, 1 bit, SHALL qualify o_mean.
REQ-010 Port o_mean, output, WID bits, SHALL carry the mean of one accepted sample set.

Function
REQ-011 The block SHALL compute o_mean = sum of the N samples divided by N, with the division set by ROUND.
REQ-012 The block SHALL be a binary adder tree of LOG2N registered stages; stage s (1..LOG2N) holds N/2**s partial sums of WID+s bits.
REQ-013 Sign extension (SIGNED=1) or zero extension (SIGNED=0) SHALL be applied at each stage before the add, so no stage overflows.
REQ-014 After the final sum stage, one output register SHALL produce o_mean.
REQ-015 Total latency SHALL be LOG2N+1 cycles: a sample set accepted at edge t appears on o_mean with out_valid=1 after edge t+LOG2N+1.
REQ-016 A valid bit SHALL travel alongside each stage; a stage register SHALL load only when its incoming valid bit is 1, and SHALL otherwise hold its value.
REQ-017 out_valid SHALL be 1 for exactly one cycle per accepted sample set; back-to-back in_valid SHALL give one result per cycle, in input order.
REQ-018 While out_valid=0, o_mean SHALL hold the last valid result.
REQ-019 With ROUND=0, o_mean SHALL equal bits [WID+LOG2N-1 : LOG2N] of the full sum, using an arithmetic shift when SIGNED=1.
REQ-020 With ROUND=1, o_mean SHALL equal (sum + 2**(LOG2N-1)) shifted right by LOG2N, computed on WID+LOG2N+1 bits. No saturation is needed because the result always fits in WID bits.
REQ-021 in_data SHALL be ignored in any cycle where in_valid=0.
REQ-022 The block SHALL have no backpressure; it SHALL always accept in_valid.

Reset
REQ-023 While rst_n=0, all stage registers, all valid bits, out_valid and o_mean SHALL be 0, taking effect immediately and independent of clk.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight sets; no result from before reset SHALL appear after rst_n returns to 1.
REQ-025 The first set accepted after reset release SHALL follow the normal LOG2N+1 latency.

Verification (WID=16, LOG2N=3 unless stated)
REQ-026 Unsigned, ROUND=0: all eight samples 0xFFFF, one valid cycle -> o_mean=0xFFFF with out_valid=1 exactly 4 cycles later; with ROUND=1 the result is also 0xFFFF.
REQ-027 Unsigned: samples 0,1,...,7 (sum 28) -> o_mean=0x0003 with ROUND=0 and 0x0004 with ROUND=1.
REQ-028 SIGNED=1: seven samples 0 and one sample 0xFFFC (-4) -> o_mean=0xFFFF with ROUND=0 and 0x0000 with ROUND=1; all samples 0x8000 -> 0x8000.
REQ-029 Ten consecutive valid sets with distinct constant values -> ten consecutive out_valid cycles with the matching means, in order; an idle gap of 3 cycles -> out_valid=0 for 3 cycles and o_mean held.
REQ-030 rst_n pulsed low for half a cycle while 3 sets are in flight -> out_valid and o_mean go to 0 at once; none of the 3 results ever appears; a new set completes 4 cycles after its acceptance.
REQ-031 Regression at LOG2N=1 and LOG2N=6 with random data checked against a reference model -> zero mismatches and latencies of 2 and 7 cycles respectively.

Source files
------------

// File: rtl/mean_tree_pipe.sv
// mean_tree_pipe: mean of N = 2**LOG2N samples through a registered binary
// adder tree (one register per tree level) followed by a divide-by-N output
// register. A valid bit runs beside every level. Each data register captures
// only when its incoming valid bit is set, so idle cycles leave it unchanged.
module mean_tree_pipe #(
  parameter int WID    = 16,
  parameter int LOG2N  = 3,
  parameter int SIGNED = 0,
  parameter int ROUND  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [(2**LOG2N)*WID-1:0]     in_data,
  output logic                          out_valid,
  output logic [WID-1:0]                o_mean
);

  localparam int N  = 2 ** LOG2N;
  localparam int SW = WID + LOG2N;           // width of the full sum
  localparam logic SX = (SIGNED != 0);       // 1 = sign-extend operands
  // Half of the divisor, added before the shift when rounding half up.
  localparam logic [SW:0] RND_ADD = (ROUND != 0) ? ((SW+1)'(1) << (LOG2N-1)) : '0;

  genvar gi, gk;

  // Level 0 is the unpacked input. Level gi holds N>>gi partial sums of WID+gi bits.
  generate
    for (gi = 0; gi <= LOG2N; gi++) begin : g_stage
      localparam int W = WID + gi;
      localparam int M = N >> gi;
      logic [W-1:0] psum [M];
      logic         vld;

      if (gi == 0) begin : g_in
        for (gk = 0; gk < M; gk++) begin : g_unpack
          assign psum[gk] = in_data[gk*WID +: WID];
        end
        assign vld = in_valid;
      end else begin : g_add
        logic [W-2:0] lhs    [M];
        logic [W-2:0] rhs    [M];
        logic [W-1:0] psum_d [M];
        logic [W-1:0] psum_q [M];
        logic         vld_d;
        logic         vld_q;

        for (gk = 0; gk < M; gk++) begin : g_pair
          assign lhs[gk] = g_stage[gi-1].psum[2*gk];
          assign rhs[gk] = g_stage[gi-1].psum[2*gk+1];
        end

        // Widen each operand by one bit before the add so the sum cannot overflow.
        always_comb begin
          vld_d = g_stage[gi-1].vld;
          for (int k = 0; k < M; k++) begin
            psum_d[k] = psum_q[k];
            if (vld_d) begin
              psum_d[k] = {SX & lhs[k][W-2], lhs[k]} + {SX & rhs[k][W-2], rhs[k]};
            end
          end
        end

        // Level register with asynchronous clear.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vld_q <= 1'b0;
            for (int k = 0; k < M; k++) begin
              psum_q[k] <= '0;
            end
          end else begin
            vld_q <= vld_d;
            for (int k = 0; k < M; k++) begin
              psum_q[k] <= psum_d[k];
            end
          end
        end

        assign psum = psum_q;
        assign vld  = vld_q;
      end
    end
  endgenerate

  logic [SW-1:0]  total;
  logic           fin_vld;
  logic [SW:0]    rnd_sum;
  logic [WID-1:0] o_mean_d;
  logic [WID-1:0] o_mean_q;
  logic           out_valid_d;
  logic           out_valid_q;
  logic           unused_bits;

  assign total   = g_stage[LOG2N].psum[0];
  assign fin_vld = g_stage[LOG2N].vld;

  // Divide by N: optional half-LSB bias, then drop the LOG2N low bits.
  // The result always fits in WID bits, so bit SW of rnd_sum is never needed.
  always_comb begin
    rnd_sum     = {SX & total[SW-1], total} + RND_ADD;
    out_valid_d = fin_vld;
    o_mean_d    = o_mean_q;
    if (fin_vld) begin
      o_mean_d = rnd_sum[SW-1:LOG2N];
    end
  end

  assign unused_bits = ^{rnd_sum[SW], rnd_sum[LOG2N-1:0]};

  // Output register: the mean holds its last value between valid results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      o_mean_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      o_mean_q    <= o_mean_d;
    end
  end

  assign out_valid = out_valid_q;
  assign o_mean    = o_mean_q;

endmodule

// File: tb/tb_mean_tree_pipe.sv
// tb_mean_tree_pipe: six configurations of mean_tree_pipe share one stimulus
// stream. A negedge scoreboard compares every cycle against an arithmetic
// mean model. A table of fixed vectors and reset/back-to-back sequences
// cover the corner cases.
module tb_mean_tree_pipe;

  // Configs: 0..3 = LOG2N 3 with {U,R0},{U,R1},{S,R0},{S,R1}; 4 = LOG2N 1 U R0; 5 = LOG2N 6 S R1
  localparam int L_OF [6] = '{3, 3, 3, 3, 1, 6};
  localparam int S_OF [6] = '{0, 0, 1, 1, 0, 1};
  localparam int R_OF [6] = '{0, 1, 0, 1, 0, 1};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   samp [64];
  logic [127:0]  din3;
  logic [31:0]   din1;
  logic [1023:0] din6;
  logic          ov [6];
  logic [15:0]   om [6];

  int cyc = 0;
  int n_pass = 0;
  int n_chk = 0;

  logic [15:0] exp_q [6][$];
  int          acc_q [6][$];
  logic [15:0] last_m [6];
  int          ov_cycles [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    din3 = '0;
    din1 = '0;
    din6 = '0;
    for (int k = 0; k < 8; k++) din3[k*16 +: 16] = samp[k];
    for (int k = 0; k < 2; k++) din1[k*16 +: 16] = samp[k];
    for (int k = 0; k < 64; k++) din6[k*16 +: 16] = samp[k];
  end

  mean_tree_pipe #(.WID(16), .LOG2N(3), .SIGNED(0), .ROUND(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(din3), .out_valid(ov[0]), .o_mean(om[0]));
  mean_tree_pipe #(.WID(16), .LOG2N(3), .SIGNED(0), .ROUND(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(din3), .out_valid(ov[1]), .o_mean(om[1]));
  mean_tree_pipe #(.WID(16), .LOG2N(3), .SIGNED(1), .ROUND(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(din3), .out_valid(ov[2]), .o_mean(om[2]));
  mean_tree_pipe #(.WID(16), .LOG2N(3), .SIGNED(1), .ROUND(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(din3), .out_valid(ov[3]), .o_mean(om[3]));
  mean_tree_pipe #(.WID(16), .LOG2N(1), .SIGNED(0), .ROUND(0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(din1), .out_valid(ov[4]), .o_mean(om[4]));
  mean_tree_pipe #(.WID(16), .LOG2N(6), .SIGNED(1), .ROUND(1)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(din6), .out_valid(ov[5]), .o_mean(om[5]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: exact mean with floor division, optional +N/2 bias first.
  function automatic logic [15:0] ref_mean(input int i);
    longint sum = 0;
    longint n;
    longint q;
    n = longint'(1) << L_OF[i];
    for (int k = 0; k < n; k++) begin
      if (S_OF[i] != 0) sum += longint'($signed(samp[k]));
      else              sum += longint'(samp[k]);
    end
    if (R_OF[i] != 0) sum += n / 2;
    q = sum / n;
    if ((sum % n) != 0 && sum < 0) q -= 1;
    return q[15:0];
  endfunction

  task automatic mon(input int i);
    bit          due;
    logic [15:0] e;
    due = (exp_q[i].size() > 0) && (cyc - acc_q[i][0] + 1 == L_OF[i] + 1);
    check($sformatf("u%0d_out_valid", i), 32'(ov[i]), 32'(due));
    if (due) begin
      e = exp_q[i].pop_front();
      void'(acc_q[i].pop_front());
      check($sformatf("u%0d_mean", i), 32'(om[i]), 32'(e));
      last_m[i] = e;
    end else begin
      check($sformatf("u%0d_hold", i), 32'(om[i]), 32'(last_m[i]));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 6; i++) mon(i);
      if (ov[0]) ov_cycles.push_back(cyc);
    end
  end

  // One input cycle; an idle cycle drives junk samples that must be ignored.
  task automatic send(input bit v);
    in_valid = v;
    if (!v) begin
      for (int k = 0; k < 64; k++) samp[k] = 16'($urandom);
    end else begin
      for (int i = 0; i < 6; i++) begin
        exp_q[i].push_back(ref_mean(i));
        acc_q[i].push_back(cyc + 1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] s [8];
    logic [15:0] e [4];
  } vec_t;

  vec_t tbl [4];

  initial begin
    for (int k = 0; k < 8; k++) begin
      tbl[0].s[k] = 16'hFFFF;
      tbl[1].s[k] = 16'(k);
      tbl[2].s[k] = 16'h0000;
      tbl[3].s[k] = 16'h8000;
    end
    tbl[2].s[5] = 16'hFFFC;
    tbl[0].e = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[1].e = '{16'h0003, 16'h0004, 16'h0003, 16'h0004};
    tbl[2].e = '{16'h1FFF, 16'h2000, 16'hFFFF, 16'h0000};
    tbl[3].e = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    for (int i = 0; i < 6; i++) last_m[i] = '0;
    for (int k = 0; k < 64; k++) samp[k] = 16'($urandom);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("u%0d_reset_valid", i), 32'(ov[i]), 32'd0);
      check($sformatf("u%0d_reset_mean", i), 32'(om[i]), 32'd0);
    end
    rst_n = 1'b1;
    send(0);

    // Fixed vectors: one valid cycle, result expected after the 4th edge
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 64; k++) samp[k] = '0;
      for (int k = 0; k < 8; k++) samp[k] = tbl[t].s[k];
      send(1);
      repeat (3) send(0);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("vec%0d_u%0d_valid", t, i), 32'(ov[i]), 32'd1);
        check($sformatf("vec%0d_u%0d_mean", t, i), 32'(om[i]), 32'(tbl[t].e[i]));
      end
      send(0);
    end
    $display("fixed vectors applied");

    // Ten back-to-back sets, a 3-cycle gap, one more set
    ov_cycles.delete();
    for (int j = 0; j < 10; j++) begin
      for (int k = 0; k < 64; k++) samp[k] = 16'(j * 1000 + 123);
      send(1);
    end
    repeat (3) send(0);
    for (int k = 0; k < 64; k++) samp[k] = 16'd5555;
    send(1);
    repeat (10) send(0);
    check("b2b_count", 32'(ov_cycles.size()), 32'd11);
    if (ov_cycles.size() == 11) begin
      check("b2b_span", 32'(ov_cycles[9] - ov_cycles[0]), 32'd9);
      check("b2b_gap", 32'(ov_cycles[10] - ov_cycles[9]), 32'd4);
    end
    $display("back-to-back sequence applied");

    // Asynchronous reset with three sets in flight
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < 64; k++) samp[k] = 16'($urandom);
      send(1);
    end
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_q[i].delete();
      acc_q[i].delete();
      last_m[i] = '0;
    end
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("u%0d_async_rst_valid", i), 32'(ov[i]), 32'd0);
      check($sformatf("u%0d_async_rst_mean", i), 32'(om[i]), 32'd0);
    end
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (8) send(0);
    for (int k = 0; k < 64; k++) samp[k] = 16'($urandom);
    send(1);
    repeat (10) send(0);
    $display("mid-run reset sequence applied");

    // Random regression across all configurations
    for (int j = 0; j < 400; j++) begin
      for (int k = 0; k < 64; k++) samp[k] = 16'($urandom);
      send($urandom_range(0, 9) < 7);
    end
    repeat (10) send(0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("u%0d_drained", i), 32'(exp_q[i].size()), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
